alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential command issuer and accumulator that drives the team's combinational N-bit ALU: it accepts (opcode, operand) commands over a valid/ready handshake and presents `{accumulator, operand, opcode}` to the ALU's operand/opcode inputs. It captures the ALU result, optionally writes it back to the accumulator, and returns it over a valid/ready response channel. It is the initiating end of the ALU interface: the ALU is instantiated alongside it, with its inputs fed from this block and its output routed back to it.

## Interface
- `N`, 3: data width; must match the attached ALU's width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  00 ADD, 01 OR, 10 SUB, 11 XOR.
- `cmd_operand`  in  N  second operand.
- `cmd_load`  in  1  1 = load `cmd_operand` into accumulator, no ALU issue; `cmd_op`/`cmd_wb` ignored.
- `cmd_wb`  in  1  1 = write ALU result back into accumulator.
- `acc_clr`  in  1  synchronous accumulator clear.
- `alu_in1`  out  N  to ALU first operand (accumulator copy).
- `alu_in0`  out  N  to ALU second operand.
- `alu_opcode`  out  2  to ALU opcode.
- `alu_out`  in  N  ALU result (combinational from the three outputs above).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  N  result (ALU result, or loaded value).
- `acc`  out  N  current accumulator.
- `rsp_carry`, `rsp_zero`  out  1 each  flags; present only under `ALU_ISSUE_FLAGS_EN`.

## Operation
- States: IDLE, ISSUE, RESP. Reset → IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, register op, operand, load and wb. Go to ISSUE.
- ISSUE: `alu_in1`=acc, `alu_in0`=operand reg, `alu_opcode`=op reg. At the end of the cycle, sample `alu_out` into the result register, or the operand reg if load. Write back to acc if wb or load. Go to RESP.
- RESP: `rsp_valid`=1, `rsp_data`=result reg, stable until handshake. On `rsp_valid && rsp_ready` go to IDLE.
- `cmd_ready`=0 in ISSUE and RESP; no queuing.
- ALU drive registers hold their last values outside ISSUE, so the ALU inputs never glitch from this block.
- Arithmetic is modulo 2^N. The accumulator wraps with no saturation.
- `acc_clr` zeroes acc on the edge where it is sampled, in any state. It has priority over write-back/load on the same edge.
- `acc_clr` together with command acceptance in IDLE: the clear applies, and the accepted command then operates on acc=0 in ISSUE.

## Timing
- Reset values: `cmd_ready`=0 during reset and 1 after release (IDLE). `rsp_valid`=0. `rsp_data`, `acc`, `alu_in1`, `alu_in0`, `alu_opcode`, and flags all 0.
- Command accepted on edge T → ALU driven during cycle T+1 → `rsp_valid`=1 from T+2.
- Minimum command spacing is 3 cycles when `rsp_ready` is held high.
- Reset asserted in any state: immediately clears all state, drops `rsp_valid`, and discards the in-flight command. The accumulator is not preserved.
- Write-back is visible on `acc` in the same cycle `rsp_valid` rises.

## Configuration
- `ALU_ISSUE_FLAGS_EN` defined:
  - `rsp_carry`/`rsp_zero` exist and are registered at the end of ISSUE, alongside the result.
  - ADD: carry = bit N of `acc + operand` at N+1 width.
  - SUB: carry = borrow (`acc < operand`, unsigned).
  - OR/XOR/load: carry = 0.
  - zero = (result == 0).
- Undefined: the ports and flag logic are absent. All other behaviour is identical.

## Structure
- Shared package `alu_issue_pkg`: opcode constants `OP_ADD`=2'b00, `OP_OR`=2'b01, `OP_SUB`=2'b10, `OP_XOR`=2'b11, and the state encoding IDLE/ISSUE/RESP.
- One sub-module, `alu_issue_flags`: combinational carry/zero computation from acc, operand, op and `alu_out`. It is instantiated only under `ALU_ISSUE_FLAGS_EN`.
- The ALU itself is not instantiated inside this block.

## Test plan
All scenarios use N=3 with the team ALU attached.
- Load then ADD wraps:
  - Stimulus: load 5, then ADD 3 wb=1.
  - Required: rsp_data=0, acc=0; with flags, carry=1, zero=1.
- SUB borrow:
  - Stimulus: load 2, then SUB 5 wb=1.
  - Required: rsp_data=5 (3'b101), acc=5, carry=1.
- OR and XOR without write-back:
  - Stimulus: acc=3'b110; OR 3'b011 wb=0, then XOR 3'b011 wb=0.
  - Required: rsp_data=7 then 5; acc stays 6 throughout.
- Latency and backpressure:
  - Stimulus: accept at T; hold `rsp_ready`=0 for 4 cycles.
  - Required: `rsp_valid` rises at T+2; `rsp_data` is stable and `cmd_ready`=0 until the handshake; IDLE on the following cycle.
- Clear priority:
  - Stimulus: assert `acc_clr` on the ISSUE edge of an ADD wb=1 with acc=4, operand 1.
  - Required: acc=0 after that edge; rsp_data=5.
- Reset mid-operation:
  - Stimulus: assert `rst` while in RESP with acc=6.
  - Required: `rsp_valid`=0, acc=0 and `alu_*`=0 immediately; `cmd_ready`=1 after release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared opcode constants and issue-FSM state encoding for alu_issue_ctrl.
package alu_issue_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/alu_issue_ctrl_flags.sv
// Combinational carry/zero flags for an issued ALU op; used only under ALU_ISSUE_FLAGS_EN.
module alu_issue_flags
  import alu_issue_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] acc_i,
  input  logic [N-1:0] opd_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] alu_out_i,
  output logic         carry_o,
  output logic         zero_o
);
  logic [N:0] sum;

  assign sum = {1'b0, acc_i} + {1'b0, opd_i};

  always_comb begin
    carry_o = 1'b0;
    case (op_i)
      OP_ADD:  carry_o = (sum >> N) != '0;
      OP_SUB:  carry_o = acc_i < opd_i;
      default: carry_o = 1'b0;
    endcase
  end

  assign zero_o = (alu_out_i == '0);
endmodule

// File: rtl/alu_issue_ctrl.sv
// Command issuer/accumulator driving an external combinational ALU.
// Optional registered carry/zero flags under `ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_operand,
  input  logic         cmd_load,
  input  logic         cmd_wb,
  input  logic         acc_clr,
  output logic [N-1:0] alu_in1,
  output logic [N-1:0] alu_in0,
  output logic [1:0]   alu_opcode,
  input  logic [N-1:0] alu_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic [N-1:0] acc
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic         rsp_carry,
  output logic         rsp_zero
`endif
);
  state_e       state_q, state_d;
  logic [N-1:0] opd_q, opd_d;
  logic         load_q, load_d, wb_q, wb_d;
  logic [N-1:0] res_q, res_d, acc_q, acc_d;
  logic [N-1:0] in1_q, in1_d, in0_q, in0_d;
  logic [1:0]   opc_q, opc_d;
  logic         accept;

  assign accept    = cmd_valid && (state_q == IDLE);
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = res_q;
  assign acc       = acc_q;
  assign alu_in1   = in1_q;
  assign alu_in0   = in0_q;
  assign alu_opcode = opc_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    opd_d  = opd_q;
    load_d = load_q;
    wb_d   = wb_q;
    res_d  = res_q;
    acc_d  = acc_q;
    in1_d  = in1_q;
    in0_d  = in0_q;
    opc_d  = opc_q;
    if (accept) begin
      opd_d  = cmd_operand;
      load_d = cmd_load;
      wb_d   = cmd_wb;
      // Loads never reach the ALU, so its drive registers keep their old values.
      if (!cmd_load) begin
        in1_d = acc_clr ? '0 : acc_q;
        in0_d = cmd_operand;
        opc_d = cmd_op;
      end
    end
    if (state_q == ISSUE) begin
      res_d = load_q ? opd_q : alu_out;
      if (load_q || wb_q) acc_d = res_d;
    end
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opd_q   <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      res_q   <= '0;
      acc_q   <= '0;
      in1_q   <= '0;
      in0_q   <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opd_q   <= opd_d;
      load_q  <= load_d;
      wb_q    <= wb_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      in1_q   <= in1_d;
      in0_q   <= in0_d;
      opc_q   <= opc_d;
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic fl_carry, fl_zero, carry_q, zero_q;

  alu_issue_flags #(.N(N)) u_flags (
    .acc_i     (in1_q),
    .opd_i     (in0_q),
    .op_i      (opc_q),
    .alu_out_i (alu_out),
    .carry_o   (fl_carry),
    .zero_o    (fl_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == ISSUE) begin
      carry_q <= load_q ? 1'b0 : fl_carry;
      zero_q  <= load_q ? (opd_q == '0) : fl_zero;
    end
  end

  assign rsp_carry = carry_q;
  assign rsp_zero  = zero_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural 3-bit team ALU attached.
module tb_alu_issue_ctrl;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [N-1:0] cmd_operand = '0;
  logic         cmd_load = 1'b0, cmd_wb = 1'b0, acc_clr = 1'b0;
  logic [N-1:0] alu_in1, alu_in0, alu_out;
  logic [1:0]   alu_opcode;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic [N-1:0] rsp_data, acc;
`ifdef ALU_ISSUE_FLAGS_EN
  logic         rsp_carry, rsp_zero;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_operand(cmd_operand), .cmd_load(cmd_load), .cmd_wb(cmd_wb),
    .acc_clr(acc_clr),
    .alu_in1(alu_in1), .alu_in0(alu_in0), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .acc(acc)
`ifdef ALU_ISSUE_FLAGS_EN
    , .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
`endif
  );

  // Team ALU: in1 is the accumulator side, in0 the operand.
  always_comb begin
    case (alu_opcode)
      2'b00:   alu_out = alu_in1 + alu_in0;
      2'b01:   alu_out = alu_in1 | alu_in0;
      2'b10:   alu_out = alu_in1 - alu_in0;
      default: alu_out = alu_in1 ^ alu_in0;
    endcase
  end

  typedef struct {
    logic [N-1:0] data;
    logic [N-1:0] acc;
    logic         c;
    logic         z;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] m_acc = '0;
  int           checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic ld, input logic [1:0] op, input logic [N-1:0] opd,
                           input logic wb, input logic clr_acc, input logic clr_iss);
    exp_t        e;
    logic [N:0]  s;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_operand = opd; cmd_wb = wb;
    acc_clr = clr_acc;
    if (clr_acc) m_acc = '0;
    s = {1'b0, m_acc} + {1'b0, opd};
    e.c = 1'b0;
    if (ld) e.data = opd;
    else begin
      case (op)
        2'b00: begin e.data = s[N-1:0]; e.c = s[N]; end
        2'b01: e.data = m_acc | opd;
        2'b10: begin e.data = m_acc - opd; e.c = (m_acc < opd); end
        default: e.data = m_acc ^ opd;
      endcase
    end
    e.z = (e.data == '0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_clr = clr_iss;
    @(negedge clk);
    chk("issue_rsp_valid", rsp_valid, 0);
    chk("issue_cmd_ready", cmd_ready, 0);
    if (!ld) begin
      chk("issue_alu_in1", alu_in1, m_acc);
      chk("issue_alu_in0", alu_in0, opd);
      chk("issue_alu_opcode", alu_opcode, op);
    end
    if (clr_iss) m_acc = '0;
    else if (ld || wb) m_acc = e.data;
    e.acc = m_acc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
  endtask

  task automatic finish_rsp(input int hold);
    exp_t         e;
    logic [N-1:0] d0;
    @(negedge clk);
    chk("rsp_latency", rsp_valid, 1);
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_stable", rsp_data, d0);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    if (sb.size() == 0) chk("sb_underflow", 1, 0);
    else begin
      e = sb.pop_front();
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_acc", acc, e.acc);
`ifdef ALU_ISSUE_FLAGS_EN
      chk("rsp_carry", rsp_carry, e.c);
      chk("rsp_zero", rsp_zero, e.z);
`endif
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
  endtask

  task automatic run(input logic ld, input logic [1:0] op, input logic [N-1:0] opd,
                     input logic wb, input logic clr_acc, input logic clr_iss, input int hold);
    start_cmd(ld, op, opd, wb, clr_acc, clr_iss);
    finish_rsp(hold);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_acc", acc, 0);
    chk("rst_alu", {alu_in1, alu_in0, alu_opcode}, 0);
`ifdef ALU_ISSUE_FLAGS_EN
    chk("rst_flags", {rsp_carry, rsp_zero}, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1);

    // load 5, ADD 3 wb -> wraps to 0
    run(1, 2'b00, 3'd5, 0, 0, 0, 0);
    run(0, 2'b00, 3'd3, 1, 0, 0, 0);
    // load 2, SUB 5 wb -> borrow, 5
    run(1, 2'b00, 3'd2, 0, 0, 0, 0);
    run(0, 2'b10, 3'd5, 1, 0, 0, 0);
    // acc=6; OR 3, XOR 3 without write-back
    run(1, 2'b00, 3'd6, 0, 0, 0, 0);
    run(0, 2'b01, 3'd3, 0, 0, 0, 0);
    run(0, 2'b11, 3'd3, 0, 0, 0, 0);
    // backpressure for 4 cycles
    run(0, 2'b00, 3'd1, 0, 0, 0, 4);
    // clear on the ISSUE edge of ADD 1 wb with acc=4
    run(1, 2'b00, 3'd4, 0, 0, 0, 0);
    run(0, 2'b00, 3'd1, 1, 0, 1, 0);
    // clear on the accept edge: ADD operates on acc=0
    run(1, 2'b00, 3'd3, 0, 0, 0, 0);
    run(0, 2'b00, 3'd2, 1, 1, 0, 0);
    // clear together with a load: load still wins at ISSUE
    run(1, 2'b00, 3'd7, 0, 1, 0, 1);

    for (int i = 0; i < 24; i++)
      run(1'($urandom_range(0, 3) == 0), 2'($urandom), 3'($urandom), 1'($urandom),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), $urandom_range(0, 2));

    // reset while in RESP with acc=6
    run(1, 2'b00, 3'd6, 0, 0, 0, 0);
    start_cmd(0, 2'b01, 3'd1, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    chk("pre_rst_acc", acc, 6);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_alu", {alu_in1, alu_in0, alu_opcode}, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    if (sb.size() != 0) void'(sb.pop_back());
    m_acc = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    run(0, 2'b00, 3'd2, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
